// File: rtl/isa_pkg.sv
// Shared definitions for the ISA I/O responder.
// - isa_state_e       : responder FSM state encoding
// - ISA_FLOAT_BYTE    : value returned on SD when a read is abandoned
// - ISA_BASE_ADDR_DEF : default I/O window base
// - ISA_TIMEOUT_DEF   : default backend-ack wait limit in clk cycles
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_DRIVE,
    ST_RELEASE
  } isa_state_e;

  localparam logic [7:0] ISA_FLOAT_BYTE    = 8'hFF;
  localparam logic [9:0] ISA_BASE_ADDR_DEF = 10'h220;
  localparam int         ISA_TIMEOUT_DEF   = 15;

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchroniser for an asynchronous active-low ISA strobe, followed by
// a falling-edge detector. All flops reset to 1 (strobe inactive).
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   strobe_n : raw asynchronous active-low strobe from the bus
//   sync_n   : strobe synchronised to clk
//   fall     : one-cycle pulse when sync_n goes 1 -> 0
module isa_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic sync_n,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= strobe_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_n = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/isa_io_responder.sv
// ISA I/O target for a 2^WIN_BITS-byte window at BASE_ADDR. IOW/IOR cycles
// are synchronised to clk and turned into backend write/read requests. Reads
// hold IOCHRDY low until backend data is available on SD_out.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   AEN                 : DMA cycle marker, strobes ignored when high
//   SA, SD_in           : ISA address and write data
//   IOW, IOR            : asynchronous active-low I/O strobes
//   SD_out, SD_oe       : read data and its bus drive enable
//   IOCHRDY             : low stretches the current ISA cycle
//   reg_addr, reg_wdata : backend register offset and write data
//   reg_wr, reg_rd      : backend requests, held until reg_ack
//   reg_rdata, reg_ack  : backend read data and completion
//   timeout_err         : one-cycle pulse when a request is abandoned
module isa_io_responder
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(ISA_BASE_ADDR_DEF),
  parameter int                WIN_BITS  = 4,
  parameter int                TIMEOUT   = ISA_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                AEN,
  input  logic [ADDR_W-1:0]   SA,
  input  logic [7:0]          SD_in,
  input  logic                IOW,
  input  logic                IOR,
  output logic [7:0]          SD_out,
  output logic                SD_oe,
  output logic                IOCHRDY,
  output logic [WIN_BITS-1:0] reg_addr,
  output logic [7:0]          reg_wdata,
  output logic                reg_wr,
  output logic                reg_rd,
  input  logic [7:0]          reg_rdata,
  input  logic                reg_ack,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic iow_sync, iow_fall;
  logic ior_sync, ior_fall;

  isa_strobe_sync u_iow_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (IOW),
    .sync_n   (iow_sync),
    .fall     (iow_fall)
  );

  isa_strobe_sync u_ior_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (IOR),
    .sync_n   (ior_sync),
    .fall     (ior_fall)
  );

  // SA/AEN are stable while a strobe is low, so they are used unsynchronised.
  logic hit;
  assign hit = !AEN && (SA[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS]);

  isa_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          sd_out_d;
  logic                sd_oe_d, iochrdy_d, reg_wr_d, reg_rd_d, timeout_d;
  logic [WIN_BITS-1:0] reg_addr_d;
  logic [7:0]          reg_wdata_d;
  logic                timed_out;

  // cnt_q counts completed wait cycles; the last allowed one is TIMEOUT-1.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: every signal gets a hold/default value before the case statement so
  // no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sd_out_d    = SD_out;
    sd_oe_d     = SD_oe;
    iochrdy_d   = IOCHRDY;
    reg_wr_d    = reg_wr;
    reg_rd_d    = reg_rd;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iow_fall && hit && ior_sync) begin
          reg_addr_d  = SA[WIN_BITS-1:0];
          reg_wdata_d = SD_in;
          reg_wr_d    = 1'b1;
          cnt_d       = '0;
          state_d     = ST_WR_REQ;
        end else if (ior_fall && hit && iow_sync) begin
          reg_addr_d = SA[WIN_BITS-1:0];
          reg_rd_d   = 1'b1;
          iochrdy_d  = 1'b0;
          cnt_d      = '0;
          state_d    = ST_RD_REQ;
        end else if ((!iow_sync && !ior_sync) || iow_fall || ior_fall) begin
          // Contention or a cycle for another target: sit it out.
          state_d = ST_RELEASE;
        end
      end

      ST_WR_REQ: begin
        // Posted write: completes even if IOW has already been released.
        if (reg_ack) begin
          reg_wr_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (timed_out) begin
          reg_wr_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_REQ: begin
        if (reg_ack) begin
          sd_out_d  = reg_rdata;
          sd_oe_d   = 1'b1;
          iochrdy_d = 1'b1;
          reg_rd_d  = 1'b0;
          state_d   = ST_RD_DRIVE;
        end else if (timed_out) begin
          // Return what an undriven bus would read.
          sd_out_d  = ISA_FLOAT_BYTE;
          sd_oe_d   = 1'b1;
          iochrdy_d = 1'b1;
          reg_rd_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_RD_DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_DRIVE: begin
        if (ior_sync) begin
          sd_oe_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_RELEASE: begin
        if (iow_sync && ior_sync) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      SD_out      <= '0;
      SD_oe       <= 1'b0;
      IOCHRDY     <= 1'b1;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      SD_out      <= sd_out_d;
      SD_oe       <= sd_oe_d;
      IOCHRDY     <= iochrdy_d;
      reg_wr      <= reg_wr_d;
      reg_rd      <= reg_rd_d;
      reg_addr    <= reg_addr_d;
      reg_wdata   <= reg_wdata_d;
      timeout_err <= timeout_d;
    end
  end

endmodule
